// File: rtl/oam_dma_master.sv
// OAM DMA bus master: copies NBYTES from page {SRC,8'h00} into OAM after a
// write to FF46, holding the core off the external bus during the copy.
module oam_dma_master #(
  parameter int NBYTES      = 160,
  parameter int START_DELAY = 4
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        REG_WE,
  input  logic [7:0]  REG_DIN,
  output logic [7:0]  REG_DOUT,
  output logic        BUSY,
  output logic        BUS_DISABLE,
  output logic        MREQ,
  output logic        RD,
  output logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic        OAM_WE,
  output logic [7:0]  OAM_A,
  output logic [7:0]  OAM_D
);

  localparam int CW = $clog2(START_DELAY + 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t          state_q, state_d;
  logic [7:0]      src_q, src_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      idx_q, idx_d;
  logic [1:0]      ph_q, ph_d;
  logic            oam_we_q, oam_we_d;
  logic [7:0]      oam_a_q, oam_a_d;
  logic [7:0]      oam_d_q, oam_d_d;
  logic [7:0]      page;
  logic            xfer;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      src_q    <= 8'hFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      ph_q     <= '0;
      oam_we_q <= 1'b0;
      oam_a_q  <= '0;
      oam_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ph_q     <= ph_d;
      oam_we_q <= oam_we_d;
      oam_a_q  <= oam_a_d;
      oam_d_q  <= oam_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ph_d     = ph_q;
    oam_we_d = 1'b0;
    oam_a_d  = oam_a_q;
    oam_d_d  = oam_d_q;
    case (state_q)
      START: begin
        if (cnt_q == CW'(START_DELAY - 1)) begin
          state_d = XFER;
          idx_d   = '0;
          ph_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          // responder has held data since RD rose; take it as phase 3 ends
          oam_we_d = 1'b1;
          oam_a_d  = idx_q;
          oam_d_d  = D_IN;
          if (idx_q == 8'(NBYTES - 1)) state_d = IDLE;
          else                         idx_d   = idx_q + 8'd1;
        end
      end
      default: ;
    endcase
    // a new write restarts from any state; a byte captured this edge still lands
    if (REG_WE) begin
      src_d   = REG_DIN;
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      ph_d    = '0;
    end
  end

  // echo RAM E0-FF aliases C0-DF
  assign page        = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
  assign xfer        = (state_q == XFER);
  assign REG_DOUT    = src_q;
  assign BUSY        = (state_q != IDLE);
  assign BUS_DISABLE = xfer;
  assign MREQ        = xfer;
  assign RD          = xfer && (ph_q != 2'd0);
  assign A           = xfer ? {page, idx_q} : 16'h0000;
  assign OAM_WE      = oam_we_q;
  assign OAM_A       = oam_a_q;
  assign OAM_D       = oam_d_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// Directed bench for oam_dma_master: memory responder plus per-cycle
// expectations derived from the E0-relative timing of each transfer.
module tb_oam_dma_master;

  logic        clk = 1'b0;
  logic        nrst;
  logic        reg_we;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        busy, bus_dis, mreq, rd;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        oam_we;
  logic [7:0]  oam_a, oam_d;

  logic [7:0]  mem [0:65535];
  int nvec = 0;
  int nerr = 0;

  oam_dma_master #(.NBYTES(160), .START_DELAY(4)) dut (
    .CLK(clk), .nRESET(nrst), .REG_WE(reg_we), .REG_DIN(reg_din),
    .REG_DOUT(reg_dout), .BUSY(busy), .BUS_DISABLE(bus_dis),
    .MREQ(mreq), .RD(rd), .A(a), .D_IN(d_in),
    .OAM_WE(oam_we), .OAM_A(oam_a), .OAM_D(oam_d)
  );

  always #5 clk = ~clk;

  // responder latches the addressed byte on the rising edge of RD
  always @(posedge rd) d_in = mem[a];

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mval(input logic [7:0] pg, input int i);
    logic [15:0] ad;
    ad = {pg, 8'(i)};
    return mem[ad];
  endfunction

  // s1 started at k=0; optional restart with s2 sampled at edge kr (kr<0: none)
  task automatic run_xfer(input string nm, input logic [7:0] s1, input logic [7:0] p1,
                          input int kr, input logic [7:0] s2, input logic [7:0] p2);
    int q_k[$];
    int q_i[$];
    int q_d[$];
    int kend, k0, r, nwe, nrd, bad_bus, bad_busy, b2b, total, exp_rd;
    logic [7:0]  pg;
    logic [15:0] ea;
    logic        xf, erd, prd, pwe;
    for (int i = 0; i < 160; i++)
      if (kr < 0 || 8 + 4*i <= kr) begin
        q_k.push_back(8 + 4*i); q_i.push_back(i); q_d.push_back(int'(mval(p1, i)));
      end
    if (kr >= 0)
      for (int i = 0; i < 160; i++) begin
        q_k.push_back(kr + 8 + 4*i); q_i.push_back(i); q_d.push_back(int'(mval(p2, i)));
      end
    total  = q_k.size();
    exp_rd = total;
    kend   = ((kr < 0) ? 0 : kr) + 644;
    nwe = 0; nrd = 0; bad_bus = 0; bad_busy = 0; b2b = 0; prd = 1'b0; pwe = 1'b0;
    reg_din = s1; reg_we = 1'b1;
    for (int k = 0; k <= kend + 4; k++) begin
      @(negedge clk);
      reg_we = 1'b0;
      k0 = (kr >= 0 && k >= kr) ? kr : 0;
      pg = (kr >= 0 && k >= kr) ? p2 : p1;
      r  = k - k0;
      xf  = (r >= 4) && (r <= 643);
      erd = xf && (((r - 4) % 4) != 0);
      ea  = xf ? {pg, 8'((r - 4) / 4)} : 16'h0000;
      if (mreq !== xf || rd !== erd || a !== ea || bus_dis !== xf) bad_bus++;
      if (busy !== (k < kend)) bad_busy++;
      if (rd && !prd) nrd++;
      prd = rd;
      if (oam_we) begin
        if (pwe) b2b++;
        nwe++;
        if (q_k.size() > 0) begin
          chk({nm, "_we_clk"}, k, q_k.pop_front());
          chk({nm, "_oam_a"}, int'(oam_a), q_i.pop_front());
          chk({nm, "_oam_d"}, int'(oam_d), q_d.pop_front());
        end else begin
          chk({nm, "_extra_we"}, nwe, total);
        end
      end
      pwe = oam_we;
      if (k == 0) chk({nm, "_busy_e0"}, int'(busy), 1);
      if (kr >= 0 && k == kr - 1) begin
        reg_din = s2; reg_we = 1'b1;
      end
    end
    chk({nm, "_we_count"}, nwe, total);
    chk({nm, "_rd_rises"}, nrd, exp_rd);
    chk({nm, "_bus_shape_bad"}, bad_bus, 0);
    chk({nm, "_busy_bad"}, bad_busy, 0);
    chk({nm, "_we_b2b"}, b2b, 0);
    chk({nm, "_reg_dout"}, int'(reg_dout), int'((kr < 0) ? s1 : s2));
  endtask

  initial begin
    int n;
    logic [15:0] av;
    for (int ad = 0; ad < 65536; ad++) begin
      av = 16'(ad);
      mem[ad] = av[7:0] ^ 8'h5A ^ (av[15:8] - 8'hC1);
    end
    d_in = 8'h00;
    // reset wins over a simultaneous register write
    nrst = 1'b0; reg_we = 1'b1; reg_din = 8'h12;
    repeat (2) @(negedge clk);
    chk("rst_reg_dout", int'(reg_dout), 'hFF);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bus_dis", int'(bus_dis), 0);
    chk("rst_a", int'(a), 0);
    chk("rst_mreq", int'(mreq), 0);
    chk("rst_rd", int'(rd), 0);
    chk("rst_oam_we", int'(oam_we), 0);
    chk("rst_oam_a", int'(oam_a), 0);
    chk("rst_oam_d", int'(oam_d), 0);
    nrst = 1'b1; reg_we = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || mreq || oam_we) n++;
    end
    chk("rst_no_start", n, 0);

    run_xfer("full", 8'hC1, 8'hC1, -1, 8'h00, 8'h00);
    run_xfer("echo", 8'hE3, 8'hC3, -1, 8'h00, 8'h00);
    run_xfer("restart", 8'hC1, 8'hC1, 8 + 4*80, 8'hD0, 8'hD0);

    // reset sampled at the edge that would capture index 40
    n = 0;
    reg_din = 8'hC1; reg_we = 1'b1;
    for (int k = 0; k < 168; k++) begin
      @(negedge clk);
      reg_we = 1'b0;
      if (oam_we) n++;
      if (k == 167) nrst = 1'b0;
    end
    chk("mid_we_before", n, 40);
    @(negedge clk);
    nrst = 1'b1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_bus_dis", int'(bus_dis), 0);
    chk("mid_mreq", int'(mreq), 0);
    chk("mid_rd", int'(rd), 0);
    chk("mid_a", int'(a), 0);
    chk("mid_oam_we", int'(oam_we), 0);
    chk("mid_oam_a", int'(oam_a), 0);
    chk("mid_oam_d", int'(oam_d), 0);
    chk("mid_reg_dout", int'(reg_dout), 'hFF);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (oam_we || busy || mreq) n++;
    end
    chk("mid_quiet_after", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
